// File: rtl/i2s_clkgen_p.sv
// -----------------------------------------------------------------------------
// i2s_clkgen_p
//
// Parametrised I2S clock generator. It derives these signals from the system
// clock:
//   - the master clock (mclk),
//   - the bit clock (bclk),
//   - the LR clock (lrclk),
//   - a frame-rate strobe (rate),
//   - one-clk enable strobes that downstream serializers use instead of
//     sampling the generated clocks.
//
// The clk/mclk ratio D = 2^(div_sel+1) can be changed at runtime. The new ratio
// is held as pending and applied only at a frame boundary, so no mclk or bclk
// period is ever truncated. While stopped (run = 0), a pending ratio is applied
// at once.
//
// Optional build macro:
//   I2S_LR_EARLY_EN
//     Defined:   lrclk switches one bit period ahead of the slot boundary
//                (Philips I2S alignment).
//     Undefined: lrclk is aligned to the slot boundary (left-justified).
//
// Parameters:
//   FS_DIV       mclk periods per frame (power of 2, 64..1024)
//   SLOT_BITS    bits per channel slot; B = FS_DIV/(2*SLOT_BITS) mclk per bit
//   DEF_DIV_SEL  ratio select loaded by reset
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   run        in   1 = generate clocks, 0 = synchronous stop
//   div_load   in   one-cycle request to change the divide ratio
//   div_sel    in   requested ratio select (sampled with div_load)
//   busy       out  ratio change pending
//   mclk       out  master clock, 50% duty
//   mclk_ena   out  one-clk strobe per mclk period
//   bclk       out  bit clock
//   bclk_fall  out  one-clk strobe at each bclk falling edge
//   lrclk      out  0 = left slot, 1 = right slot
//   rate       out  one-clk strobe per frame
// -----------------------------------------------------------------------------
module i2s_clkgen_p #(
    parameter int FS_DIV      = 256,
    parameter int SLOT_BITS   = 32,
    parameter int DEF_DIV_SEL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       div_load,
    input  logic [1:0] div_sel,
    output logic       busy,
    output logic       mclk,
    output logic       mclk_ena,
    output logic       bclk,
    output logic       bclk_fall,
    output logic       lrclk,
    output logic       rate
);

    // mclk periods per bit, and the counter widths derived from it
    localparam int B  = FS_DIV / (2 * SLOT_BITS);
    localparam int FW = $clog2(FS_DIV);
    localparam int BW = $clog2(B);

    localparam logic [FW-1:0] FCNT_MAX = FW'(FS_DIV - 1);
    localparam logic [1:0]    DEF_SEL  = 2'(DEF_DIV_SEL);
`ifdef I2S_LR_EARLY_EN
    localparam logic [FW-1:0] B_OFS    = FW'(B);
`endif

    // Reload value D-1 of the mclk down counter for a given ratio select.
    function automatic logic [3:0] div_reload(input logic [1:0] sel);
        logic [3:0] val;
        case (sel)
            2'd0:    val = 4'd1;
            2'd1:    val = 4'd3;
            2'd2:    val = 4'd7;
            2'd3:    val = 4'd15;
            default: val = 4'd3;
        endcase
        return val;
    endfunction

    // Half period D/2 (in clk) for a given ratio select.
    function automatic logic [3:0] div_half(input logic [1:0] sel);
        logic [3:0] val;
        case (sel)
            2'd0:    val = 4'd1;
            2'd1:    val = 4'd2;
            2'd2:    val = 4'd4;
            2'd3:    val = 4'd8;
            default: val = 4'd2;
        endcase
        return val;
    endfunction

    // State registers
    logic [3:0]    mcnt_r;
    logic [FW-1:0] fcnt_r;
    logic [1:0]    div_act_r;
    logic [1:0]    pending_r;
    logic          busy_r;
    logic          mclk_r;
    logic          mclk_ena_r;
    logic          bclk_r;
    logic          bclk_fall_r;
    logic          lrclk_r;
    logic          rate_r;

    // Next-state signals
    logic          wrap_s;
    logic          frame_wrap_s;
    logic          apply_s;
    logic [1:0]    div_act_nx_s;
    logic [3:0]    mcnt_nx_s;
    logic [FW-1:0] fcnt_new_s;
    logic [FW-1:0] lr_src_s;
    logic          mclk_hi_s;

    // Next-state logic for counters, ratio application and the mclk level
    always_comb begin
        wrap_s       = (mcnt_r == 4'd0);
        frame_wrap_s = wrap_s && (fcnt_r == FCNT_MAX);
        // FS_DIV is a power of 2, so the natural wrap of fcnt gives the modulo.
        fcnt_new_s   = fcnt_r + FW'(1);

`ifdef I2S_LR_EARLY_EN
        // Looking one bit period ahead makes lrclk lead the slot boundary.
        lr_src_s = fcnt_new_s + B_OFS;
`else
        lr_src_s = fcnt_new_s;
`endif

        // A load in the same cycle always wins: it only updates pending, and
        // the change is taken at the next opportunity.
        if (run) begin
            apply_s = frame_wrap_s && busy_r && !div_load;
        end else begin
            apply_s = busy_r && !div_load;
        end

        if (apply_s) begin
            div_act_nx_s = pending_r;
        end else begin
            div_act_nx_s = div_act_r;
        end

        // Reload with the ratio that is in force after this edge, so that a
        // newly applied D starts its first mclk period cleanly.
        if (!run || wrap_s) begin
            mcnt_nx_s = div_reload(div_act_nx_s);
        end else begin
            mcnt_nx_s = mcnt_r - 4'd1;
        end

        // mclk rises with the wrap and stays high D/2 clks. Gating with the
        // current level keeps mclk low after reset or stop until the first wrap.
        mclk_hi_s = wrap_s || (mclk_r && (mcnt_r > div_half(div_act_r)));
    end

    // Counters and divide-ratio control
    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_r    <= div_reload(DEF_SEL);
            fcnt_r    <= FCNT_MAX;
            div_act_r <= DEF_SEL;
            pending_r <= DEF_SEL;
            busy_r    <= 1'b0;
        end else begin
            mcnt_r    <= mcnt_nx_s;
            div_act_r <= div_act_nx_s;

            if (div_load) begin
                pending_r <= div_sel;
                busy_r    <= 1'b1;
            end else if (apply_s) begin
                busy_r    <= 1'b0;
            end else begin
                busy_r    <= busy_r;
            end

            if (!run) begin
                fcnt_r <= FCNT_MAX;
            end else if (wrap_s) begin
                fcnt_r <= fcnt_new_s;
            end else begin
                fcnt_r <= fcnt_r;
            end
        end
    end

    // Registered clock and strobe outputs
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            mclk_r      <= 1'b0;
            mclk_ena_r  <= 1'b0;
            bclk_r      <= 1'b0;
            bclk_fall_r <= 1'b0;
            lrclk_r     <= 1'b0;
            rate_r      <= 1'b0;
        end else begin
            mclk_r      <= mclk_hi_s;
            mclk_ena_r  <= wrap_s;
            rate_r      <= frame_wrap_s;
            bclk_fall_r <= wrap_s && (fcnt_new_s[BW-1:0] == BW'(0));
            if (wrap_s) begin
                // With B a power of 2, the top bit of (fcnt mod B) gives
                // "second half of the bit", and the top bit of the frame
                // position gives "right slot".
                bclk_r  <= fcnt_new_s[BW-1];
                lrclk_r <= lr_src_s[FW-1];
            end else begin
                bclk_r  <= bclk_r;
                lrclk_r <= lrclk_r;
            end
        end
    end

    assign busy      = busy_r;
    assign mclk      = mclk_r;
    assign mclk_ena  = mclk_ena_r;
    assign bclk      = bclk_r;
    assign bclk_fall = bclk_fall_r;
    assign lrclk     = lrclk_r;
    assign rate      = rate_r;

endmodule
